mvb_rr_arbiter: RTL
===================

MVB_RR_ARBITER -- requirements
Module: mvb_rr_arbiter

Interface
REQ-001 Generic RX_PORTS, default 4, number of MVB input ports (2..16).
REQ-002 Generic ITEMS, default 4, items per MVB word.
REQ-003 Generic ITEM_WIDTH, default 8, bits per item.
REQ-004 Port CLK  in  1  single clock; all logic on rising edge.
REQ-005 Port RESET  in  1  synchronous, active-high reset.
REQ-006 Port RX_DATA  in  RX_PORTS*ITEMS*ITEM_WIDTH  per-port MVB data; port p occupies slice p.
REQ-007 Port RX_VLD  in  RX_PORTS*ITEMS  per-port item valid bits.
REQ-008 Port RX_SRC_RDY  in  RX_PORTS  per-port word offered.
REQ-009 Port RX_DST_RDY  out  RX_PORTS  per-port word accepted.
REQ-010 Port TX_DATA  out  ITEMS*ITEM_WIDTH  merged MVB data.
REQ-011 Port TX_VLD  out  ITEMS  merged item valid bits.
REQ-012 Port TX_SRC_RDY  out  1  output word present.
REQ-013 Port TX_DST_RDY  in  1  downstream accepts.
REQ-014 Port TX_PORT  out  log2(RX_PORTS)  index of source port of current TX word.

Function
REQ-015 Transfer on any MVB port occurs only in a cycle where SRC_RDY and DST_RDY are both 1.
REQ-016 Arbitration granularity SHALL be one whole MVB word; items of different ports never mix in one TX word.
REQ-017 Output stage SHALL be a single register; "can_accept" = (TX_SRC_RDY=0) or (TX_DST_RDY=1).
REQ-018 When can_accept=1, the grant SHALL go to the first port with RX_SRC_RDY=1 searching from the pointer PTR upward, wrapping RX_PORTS-1 -> 0.
REQ-019 RX_DST_RDY SHALL be 1 only for the granted port and only when can_accept=1; all others 0; RX_DST_RDY SHALL not depend on TX_DST_RDY beyond can_accept.
REQ-020 On a grant to port g, PTR SHALL become (g+1) mod RX_PORTS in the next cycle; with no grant PTR SHALL hold.
REQ-021 Granted word SHALL appear on TX_DATA/TX_VLD/TX_PORT with TX_SRC_RDY=1 exactly one cycle after the transfer (latency 1).
REQ-022 A granted word with all RX_VLD bits 0 SHALL be consumed but not forwarded (TX_SRC_RDY=0 next cycle unless refilled), and PTR still advances.
REQ-023 If TX_DST_RDY=1 and a new grant occur in the same cycle, the output register SHALL be replaced with no bubble (full throughput, one word per cycle).
REQ-024 While TX_SRC_RDY=1 and TX_DST_RDY=0, TX_DATA, TX_VLD and TX_PORT SHALL remain stable.
REQ-025 Item order and positions within a word SHALL be preserved unchanged.
REQ-026 No port with continuous SRC_RDY SHALL wait more than RX_PORTS-1 grants to other ports.

Reset
REQ-027 During RESET=1: TX_SRC_RDY=0, RX_DST_RDY all 0, PTR=0, TX_VLD=0, TX_PORT=0; TX_DATA unspecified.
REQ-028 Reset asserted mid-transfer SHALL discard the output word; first cycle after release arbitration starts from port 0.

Configuration
REQ-029 Macro MVB_RR_ARBITER_STATS_EN: when defined, adds ports STAT_CLR (in, 1) and STAT_GRANTS (out, RX_PORTS*32) holding per-port 32-bit saturating counts of forwarded (non-empty) words; cleared by RESET or STAT_CLR, STAT_CLR taking priority over a same-cycle increment.
REQ-030 Without the macro the ports and counters SHALL not exist and behaviour of REQ-015..REQ-028 is identical.

Structure
REQ-031 Shared package mvb_arb_pkg SHALL hold STAT_WIDTH=32 and the function rr_next(req, ptr) returning grant index and valid.
REQ-032 One sub-module mvb_rr_select (combinational priority search from PTR) is natural; register stage and counters stay in top.

Verification
REQ-033 Ports 0..3 all SRC_RDY constantly, TX_DST_RDY=1 -> TX_PORT sequence 0,1,2,3,0,... one word per cycle.
REQ-034 Only port 2 requesting, PTR=3 -> grant wraps to port 2; next grant still 2; PTR=3 after each.
REQ-035 TX_DST_RDY=0 for 5 cycles with word from port 1 (RX_VLD=0b1010) -> TX stable 5 cycles, all RX_DST_RDY=0, then delivered once.
REQ-036 Port 0 offers RX_VLD=0b0000 then 0b0001 -> first consumed silently, only second forwarded; STAT_GRANTS[0]=1 with macro.
REQ-037 RESET pulsed while TX_SRC_RDY=1 -> TX_SRC_RDY=0 next cycle, word lost, next grant from port 0.
REQ-038 Random SRC_RDY/DST_RDY, 10000 words, scoreboard per port -> all non-empty words delivered in per-port order, fairness bound REQ-026 holds.

Source files
------------

// File: rtl/mvb_arb_pkg.sv
// Shared definitions for the MVB round-robin arbiter.
//   STAT_WIDTH : width of each per-port forwarded-word counter
//   rr_next()  : round-robin search over a request vector, starting at ptr
// Requests are passed zero-padded to MAX_PORTS bits. The search runs modulo
// MAX_PORTS, so for a narrower arbiter the padded (always-zero) positions are
// simply skipped. That gives the same order as wrapping at the real port count,
// provided ptr is a valid port index.
package mvb_arb_pkg;

  localparam int STAT_WIDTH = 32;
  localparam int MAX_PORTS  = 16;
  localparam int MAX_PW     = 4;

  typedef struct packed {
    logic              vld;
    logic [MAX_PW-1:0] idx;
  } rr_gnt_t;

  function automatic rr_gnt_t rr_next(input logic [MAX_PORTS-1:0] req,
                                      input logic [MAX_PW-1:0]    ptr);
    rr_gnt_t           g;
    logic [MAX_PW-1:0] k;
    g = '0;
    // Walk from the farthest offset down to the nearest one, so the last hit
    // is the first requester at or above ptr.
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      k = ptr + MAX_PW'(i);
      if (req[k]) begin
        g.vld = 1'b1;
        g.idx = k;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mvb_rr_select.sv
// Combinational round-robin selector.
//   i_req    : per-port request (SRC_RDY)
//   i_ptr    : current priority pointer (the first port examined)
//   o_vld    : at least one port is requesting
//   o_idx    : index of the selected port
//   o_onehot : one-hot form of o_idx, or all zeros when o_vld=0
module mvb_rr_select
  import mvb_arb_pkg::*;
#(
  parameter int RX_PORTS = 4,
  parameter int PW       = $clog2(RX_PORTS)
) (
  input  logic [RX_PORTS-1:0] i_req,
  input  logic [PW-1:0]       i_ptr,
  output logic                o_vld,
  output logic [PW-1:0]       o_idx,
  output logic [RX_PORTS-1:0] o_onehot
);

  rr_gnt_t w_gnt;
  logic    w_unused_idx;

  assign w_gnt    = rr_next(MAX_PORTS'(i_req), MAX_PW'(i_ptr));
  assign o_vld    = w_gnt.vld;
  assign o_idx    = w_gnt.idx[PW-1:0];
  assign o_onehot = o_vld ? (RX_PORTS'(1) << o_idx) : '0;

  // The upper index bits are always zero for narrow arbiters.
  assign w_unused_idx = ^w_gnt.idx;

endmodule

// File: rtl/mvb_rr_arbiter.sv
// Round-robin merge of RX_PORTS MVB streams into a single MVB stream.
// The arbiter grants one whole word per cycle and registers it once,
// giving a latency of 1 at full throughput.
//   CLK, RESET    : clock; synchronous active-high reset
//   RX_DATA/RX_VLD: per-port words and item valid bits; port p is slice p
//   RX_SRC_RDY    : per-port "word offered"
//   RX_DST_RDY    : per-port "word accepted" (one-hot or all zeros)
//   TX_DATA/TX_VLD: merged word and item valid bits
//   TX_SRC_RDY    : output register holds a word
//   TX_DST_RDY    : downstream accepts the word
//   TX_PORT       : source port of the current TX word
// Optional macro MVB_RR_ARBITER_STATS_EN adds:
//   STAT_CLR      : clears all counters; wins over a same-cycle increment
//   STAT_GRANTS   : per-port 32-bit saturating counts of forwarded words
module mvb_rr_arbiter
  import mvb_arb_pkg::*;
#(
  parameter int RX_PORTS   = 4,   // 2..16
  parameter int ITEMS      = 4,
  parameter int ITEM_WIDTH = 8
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic [RX_PORTS*ITEMS*ITEM_WIDTH-1:0] RX_DATA,
  input  logic [RX_PORTS*ITEMS-1:0]            RX_VLD,
  input  logic [RX_PORTS-1:0]                  RX_SRC_RDY,
  output logic [RX_PORTS-1:0]                  RX_DST_RDY,
  output logic [ITEMS*ITEM_WIDTH-1:0]          TX_DATA,
  output logic [ITEMS-1:0]                     TX_VLD,
  output logic                                 TX_SRC_RDY,
  input  logic                                 TX_DST_RDY,
  output logic [$clog2(RX_PORTS)-1:0]          TX_PORT
`ifdef MVB_RR_ARBITER_STATS_EN
  ,
  input  logic                                 STAT_CLR,
  output logic [RX_PORTS*STAT_WIDTH-1:0]       STAT_GRANTS
`endif
);

  localparam int PW = $clog2(RX_PORTS);
  localparam int WW = ITEMS * ITEM_WIDTH;

  logic [RX_PORTS-1:0][WW-1:0]    w_rx_data;
  logic [RX_PORTS-1:0][ITEMS-1:0] w_rx_vld;

  logic                w_can_accept;
  logic                w_sel_vld;
  logic [PW-1:0]       w_gnt_idx;
  logic [RX_PORTS-1:0] w_gnt_oh;
  logic                w_grant;
  logic                w_fwd;
  logic [PW-1:0]       w_ptr_nxt;

  logic [PW-1:0]       r_ptr;
  logic                r_tx_src_rdy;
  logic [WW-1:0]       r_tx_data;
  logic [ITEMS-1:0]    r_tx_vld;
  logic [PW-1:0]       r_tx_port;

  assign w_rx_data = RX_DATA;
  assign w_rx_vld  = RX_VLD;

  mvb_rr_select #(
    .RX_PORTS (RX_PORTS),
    .PW       (PW)
  ) u_select (
    .i_req    (RX_SRC_RDY),
    .i_ptr    (r_ptr),
    .o_vld    (w_sel_vld),
    .o_idx    (w_gnt_idx),
    .o_onehot (w_gnt_oh)
  );

  // The register is free when it is empty, or when its word leaves this cycle.
  assign w_can_accept = ~r_tx_src_rdy | TX_DST_RDY;
  assign w_grant      = w_can_accept & w_sel_vld & ~RESET;
  // A word with no valid items is consumed but never reaches the output.
  assign w_fwd        = w_grant & (|w_rx_vld[w_gnt_idx]);
  assign RX_DST_RDY   = w_grant ? w_gnt_oh : '0;
  assign w_ptr_nxt    = (w_gnt_idx == PW'(RX_PORTS - 1)) ? '0 : w_gnt_idx + PW'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ptr        <= '0;
      r_tx_src_rdy <= 1'b0;
      r_tx_vld     <= '0;
      r_tx_port    <= '0;
    end else begin
      if (w_grant)      r_ptr        <= w_ptr_nxt;
      if (w_can_accept) r_tx_src_rdy <= w_fwd;
      if (w_fwd) begin
        r_tx_vld  <= w_rx_vld[w_gnt_idx];
        r_tx_port <= w_gnt_idx;
      end
    end
  end

  // Data is qualified by TX_SRC_RDY and needs no reset.
  always_ff @(posedge CLK) begin
    if (w_fwd) r_tx_data <= w_rx_data[w_gnt_idx];
  end

  assign TX_SRC_RDY = r_tx_src_rdy;
  assign TX_DATA    = r_tx_data;
  assign TX_VLD     = r_tx_vld;
  assign TX_PORT    = r_tx_port;

`ifdef MVB_RR_ARBITER_STATS_EN
  logic [RX_PORTS-1:0][STAT_WIDTH-1:0] r_stat;

  always_ff @(posedge CLK) begin
    for (int p = 0; p < RX_PORTS; p++) begin
      if (RESET || STAT_CLR)
        r_stat[p] <= '0;
      else if (w_fwd && (w_gnt_idx == PW'(p)) && ~&r_stat[p])
        r_stat[p] <= r_stat[p] + 1'b1;
    end
  end

  assign STAT_GRANTS = r_stat;
`endif

endmodule
